// File: rtl/si_cmd_decoder.sv
//
// si_cmd_decoder
// --------------
// Host-link command decoder. Consumes the byte stream coming out of the FT245
// simple interface and turns it into register-bus transactions:
//
//   write frame : H (H[7]=1, H[6:0]=address), data low byte, data high byte
//                 -> one-cycle reg_we strobe with reg_addr/reg_wdata
//   read frame  : H (H[7]=0, H[6:0]=address)
//                 -> one-cycle reg_re strobe, wait for reg_rvalid, then return
//                    the 16-bit result to the host as low byte, high byte
//
// A partial write frame, or a read that never gets reg_rvalid, is abandoned
// after TIMEOUT_CYCLES idle cycles. Each abandonment pulses frame_err and
// bumps the saturating err_cnt. A timed-out read still answers the host with
// 16'hFFFF so the host side never stalls waiting for two bytes.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   rx_data_si          received byte, valid while rx_rdy_si is high
//   rx_rdy_si           upstream has a byte for us
//   rx_ack_si           registered one-cycle accept pulse back to upstream
//   tx_data_si          byte offered to upstream
//   tx_rdy_si           tx_data_si is valid, held until tx_ack_si
//   tx_ack_si           upstream took tx_data_si this cycle
//   reg_addr            register address of the current/last frame
//   reg_wdata           write data of the current/last write frame
//   reg_we, reg_re      one-cycle write / read strobes
//   reg_rdata           read data, qualified by reg_rvalid
//   reg_rvalid          read data valid
//   frame_err           one-cycle pulse whenever a timeout fires
//   err_cnt             number of timeouts seen, saturating at 255
//
module si_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data_si,
   input  logic        rx_rdy_si,
   output logic        rx_ack_si,
   output logic [7:0]  tx_data_si,
   output logic        tx_rdy_si,
   input  logic        tx_ack_si,
   output logic [6:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_we,
   output logic        reg_re,
   input  logic [15:0] reg_rdata,
   input  logic        reg_rvalid,
   output logic        frame_err,
   output logic [7:0]  err_cnt
);

   localparam int CntW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_LO,
      WR_HI,
      WR_ISSUE,
      RD_REQ,
      RD_WAIT,
      TX_LO,
      TX_HI
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic              rxAck_q;
   logic              rxAck_d;
   logic [6:0]        addr_q;
   logic [6:0]        addr_d;
   logic [15:0]       wdata_q;
   logic [15:0]       wdata_d;
   logic [15:0]       rdata_q;
   logic [15:0]       rdata_d;
   logic              we_q;
   logic              we_d;
   logic              re_q;
   logic              re_d;
   logic              frameErr_q;
   logic              frameErr_d;
   logic [7:0]        errCnt_q;
   logic [7:0]        errCnt_d;
   logic [CntW-1:0]   tmr_q;
   logic [CntW-1:0]   tmr_d;

   logic              byteTaken;
   logic              timerAtMax;

   // All state lives here: the FSM state plus the datapath registers that the
   // next-state logic computes alongside it. Reset is asynchronous so that a
   // reset in the middle of a frame wipes the partial frame immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rxAck_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         frameErr_q <= 1'b0;
         errCnt_q   <= '0;
         tmr_q      <= '0;
      end else begin
         state_q    <= state_d;
         rxAck_q    <= rxAck_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         we_q       <= we_d;
         re_q       <= re_d;
         frameErr_q <= frameErr_d;
         errCnt_q   <= errCnt_d;
         tmr_q      <= tmr_d;
      end
   end

   // Next-state and datapath update. A byte is only taken in the three
   // frame-collecting states and never in the cycle where our previous ack is
   // still visible, because upstream keeps rx_rdy_si high during that cycle
   // and the same byte must not be acknowledged twice.
   // The strobe states WR_ISSUE and RD_REQ last two cycles: the first cycle
   // arms the registered strobe, the second cycle is the strobe itself, and
   // the state moves on once the strobe register shows it has been issued.
   // In the timed states an incoming byte or rvalid is checked before the
   // timeout, so an event in the expiry cycle still wins.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      we_d       = 1'b0;
      re_d       = 1'b0;
      frameErr_d = 1'b0;

      byteTaken  = rx_rdy_si && !rxAck_q &&
                   (state_q inside {IDLE, WR_LO, WR_HI});
      timerAtMax = (tmr_q == CntMax);

      unique case (state_q)
         IDLE: begin
            if (byteTaken) begin
               addr_d  = rx_data_si[6:0];
               state_d = rx_data_si[7] ? WR_LO : RD_REQ;
            end
         end

         WR_LO: begin
            if (byteTaken) begin
               wdata_d[7:0] = rx_data_si;
               state_d      = WR_HI;
            end else if (timerAtMax) begin
               frameErr_d = 1'b1;
               state_d    = IDLE;
            end
         end

         WR_HI: begin
            if (byteTaken) begin
               wdata_d[15:8] = rx_data_si;
               state_d       = WR_ISSUE;
            end else if (timerAtMax) begin
               frameErr_d = 1'b1;
               state_d    = IDLE;
            end
         end

         WR_ISSUE: begin
            if (we_q) begin
               state_d = IDLE;
            end else begin
               we_d = 1'b1;
            end
         end

         RD_REQ: begin
            if (re_q) begin
               state_d = RD_WAIT;
            end else begin
               re_d = 1'b1;
            end
         end

         RD_WAIT: begin
            if (reg_rvalid) begin
               rdata_d = reg_rdata;
               state_d = TX_LO;
            end else if (timerAtMax) begin
               rdata_d    = 16'hFFFF;
               frameErr_d = 1'b1;
               state_d    = TX_LO;
            end
         end

         TX_LO: begin
            if (tx_ack_si) begin
               state_d = TX_HI;
            end
         end

         TX_HI: begin
            if (tx_ack_si) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      rxAck_d = byteTaken;

      if ((state_d == state_q) && (state_q inside {WR_LO, WR_HI, RD_WAIT})) begin
         tmr_d = tmr_q + 1'b1;
      end else begin
         tmr_d = '0;
      end

      if (frameErr_d && (errCnt_q != 8'hFF)) begin
         errCnt_d = errCnt_q + 8'd1;
      end else begin
         errCnt_d = errCnt_q;
      end
   end

   // Output decode. The TX side is a pure function of the state and the
   // captured read data; everything else is driven straight from registers
   // so the register bus and the RX handshake see glitch-free signals.
   always_comb begin
      tx_rdy_si  = 1'b0;
      tx_data_si = 8'h00;
      unique case (state_q)
         TX_LO: begin
            tx_rdy_si  = 1'b1;
            tx_data_si = rdata_q[7:0];
         end
         TX_HI: begin
            tx_rdy_si  = 1'b1;
            tx_data_si = rdata_q[15:8];
         end
         default: begin
            tx_rdy_si  = 1'b0;
            tx_data_si = 8'h00;
         end
      endcase

      rx_ack_si = rxAck_q;
      reg_addr  = addr_q;
      reg_wdata = wdata_q;
      reg_we    = we_q;
      reg_re    = re_q;
      frame_err = frameErr_q;
      err_cnt   = errCnt_q;
   end

endmodule

// File: tb/tb_si_cmd_decoder.sv
//
// tb_si_cmd_decoder
// -----------------
// Directed testbench for si_cmd_decoder with a short timeout (16 cycles) so
// timeout paths are reachable quickly. Stimulus runs as one linear sequence;
// a small monitor counts strobe and pulse occurrences so the sequence can
// compare them against hand-computed totals.
//
module tb_si_cmd_decoder;

   localparam int TimeoutCycles = 16;

   logic        clk;
   logic        rst;
   logic [7:0]  rxData;
   logic        rxRdy;
   logic        rxAck;
   logic [7:0]  txData;
   logic        txRdy;
   logic        txAck;
   logic [6:0]  regAddr;
   logic [15:0] regWdata;
   logic        regWe;
   logic        regRe;
   logic [15:0] regRdata;
   logic        regRvalid;
   logic        frameErr;
   logic [7:0]  errCnt;

   int checks = 0;
   int errors = 0;

   int weCount = 0;
   int reCount = 0;
   int ackCount = 0;
   int errPulseCount = 0;

   int baseWe;
   int baseRe;
   int baseAck;
   int baseErr;

   si_cmd_decoder #(
      .TIMEOUT_CYCLES(TimeoutCycles)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data_si (rxData),
      .rx_rdy_si  (rxRdy),
      .rx_ack_si  (rxAck),
      .tx_data_si (txData),
      .tx_rdy_si  (txRdy),
      .tx_ack_si  (txAck),
      .reg_addr   (regAddr),
      .reg_wdata  (regWdata),
      .reg_we     (regWe),
      .reg_re     (regRe),
      .reg_rdata  (regRdata),
      .reg_rvalid (regRvalid),
      .frame_err  (frameErr),
      .err_cnt    (errCnt)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse/strobe counters, sampled mid-cycle and ignored while in reset.
   always @(negedge clk) begin
      if (!rst) begin
         if (regWe)    weCount       <= weCount + 1;
         if (regRe)    reCount       <= reCount + 1;
         if (rxAck)    ackCount      <= ackCount + 1;
         if (frameErr) errPulseCount <= errPulseCount + 1;
      end
   end

   // Hard stop in case the sequence ever wedges.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance n cycles; afterwards we sit 1 unit past the rising edge.
   task automatic stepCycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one byte like the FT245 front end: hold rx_rdy until ack is seen,
   // keep it up for the ack cycle, drop it the cycle after. If the byte is
   // sampled in cycle t, this returns in cycle t+2.
   task automatic applyStimulus(input logic [7:0] b);
      int waited;
      waited = 0;
      rxData = b;
      rxRdy  = 1'b1;
      while (!rxAck && waited < 100) begin
         stepCycle(1);
         waited++;
      end
      checkOutput("rx_ack_seen", 32'(rxAck), 32'd1);
      stepCycle(1);
      rxRdy = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      rxData    = 8'h00;
      rxRdy     = 1'b0;
      txAck     = 1'b0;
      regRdata  = 16'h0000;
      regRvalid = 1'b0;

      #12;
      checkOutput("rst_rx_ack",    32'(rxAck),    32'd0);
      checkOutput("rst_tx_rdy",    32'(txRdy),    32'd0);
      checkOutput("rst_tx_data",   32'(txData),   32'd0);
      checkOutput("rst_reg_addr",  32'(regAddr),  32'd0);
      checkOutput("rst_reg_wdata", 32'(regWdata), 32'd0);
      checkOutput("rst_reg_we",    32'(regWe),    32'd0);
      checkOutput("rst_reg_re",    32'(regRe),    32'd0);
      checkOutput("rst_frame_err", 32'(frameErr), 32'd0);
      checkOutput("rst_err_cnt",   32'(errCnt),   32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stepCycle(2);

      // Write 0x1234 to 0x05 with uneven gaps between bytes.
      $display("[TB] write frame");
      baseWe  = weCount;
      baseAck = ackCount;
      baseErr = errPulseCount;
      applyStimulus(8'h85);
      applyStimulus(8'h34);
      stepCycle(5);
      applyStimulus(8'h12);
      checkOutput("wr_we_latency", 32'(regWe),    32'd1);
      checkOutput("wr_addr",       32'(regAddr),  32'h05);
      checkOutput("wr_data",       32'(regWdata), 32'h1234);
      stepCycle(1);
      checkOutput("wr_we_width",   32'(regWe),    32'd0);
      stepCycle(2);
      checkOutput("wr_we_count",   32'(weCount - baseWe),        32'd1);
      checkOutput("wr_ack_count",  32'(ackCount - baseAck),      32'd3);
      checkOutput("wr_no_err",     32'(errPulseCount - baseErr), 32'd0);

      // Read 0x03, data 0xBEEF three cycles after reg_re, slow TX acks.
      $display("[TB] read frame");
      baseRe = reCount;
      applyStimulus(8'h03);
      checkOutput("rd_re_latency", 32'(regRe),   32'd1);
      checkOutput("rd_addr",       32'(regAddr), 32'h03);
      stepCycle(3);
      checkOutput("rd_no_tx_early", 32'(txRdy), 32'd0);
      regRdata  = 16'hBEEF;
      regRvalid = 1'b1;
      stepCycle(1);
      regRvalid = 1'b0;
      regRdata  = 16'h0000;
      checkOutput("rd_tx_lo_rdy",  32'(txRdy),  32'd1);
      checkOutput("rd_tx_lo_data", 32'(txData), 32'hEF);
      for (int i = 0; i < 7; i++) begin
         stepCycle(1);
         checkOutput("rd_tx_lo_stable", 32'({txRdy, txData}), 32'h1EF);
      end
      txAck = 1'b1;
      stepCycle(1);
      txAck = 1'b0;
      checkOutput("rd_tx_hi", 32'({txRdy, txData}), 32'h1BE);
      for (int i = 0; i < 7; i++) begin
         stepCycle(1);
         checkOutput("rd_tx_hi_stable", 32'({txRdy, txData}), 32'h1BE);
      end
      txAck = 1'b1;
      stepCycle(1);
      txAck = 1'b0;
      checkOutput("rd_tx_done",  32'(txRdy), 32'd0);
      checkOutput("rd_re_count", 32'(reCount - baseRe), 32'd1);

      // Write timeout: header + low byte, then silence.
      $display("[TB] write timeout");
      baseWe = weCount;
      applyStimulus(8'h81);
      applyStimulus(8'h11);
      stepCycle(14);
      checkOutput("wto_not_yet",   32'(frameErr), 32'd0);
      stepCycle(1);
      checkOutput("wto_frame_err", 32'(frameErr), 32'd1);
      checkOutput("wto_err_cnt",   32'(errCnt),   32'd1);
      stepCycle(1);
      checkOutput("wto_pulse_width", 32'(frameErr), 32'd0);
      checkOutput("wto_no_we",       32'(weCount - baseWe), 32'd0);
      applyStimulus(8'h82);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      checkOutput("wto_next_we",   32'(regWe),    32'd1);
      checkOutput("wto_next_addr", 32'(regAddr),  32'h02);
      checkOutput("wto_next_data", 32'(regWdata), 32'h0100);
      stepCycle(2);

      // Read timeout: no rvalid, host gets 0xFFFF, late rvalid ignored.
      $display("[TB] read timeout");
      applyStimulus(8'h07);
      checkOutput("rto_re", 32'(regRe), 32'd1);
      stepCycle(16);
      checkOutput("rto_not_yet",   32'(frameErr), 32'd0);
      checkOutput("rto_no_tx_yet", 32'(txRdy),    32'd0);
      stepCycle(1);
      checkOutput("rto_frame_err", 32'(frameErr), 32'd1);
      checkOutput("rto_tx_lo",     32'({txRdy, txData}), 32'h1FF);
      checkOutput("rto_err_cnt",   32'(errCnt),   32'd2);
      regRdata  = 16'h1234;
      regRvalid = 1'b1;
      stepCycle(1);
      regRvalid = 1'b0;
      checkOutput("rto_late_rvalid", 32'({txRdy, txData}), 32'h1FF);
      txAck = 1'b1;
      stepCycle(1);
      txAck = 1'b0;
      checkOutput("rto_tx_hi", 32'({txRdy, txData}), 32'h1FF);
      txAck = 1'b1;
      stepCycle(1);
      txAck = 1'b0;
      checkOutput("rto_tx_done", 32'(txRdy), 32'd0);

      // Backpressure: a byte waits upstream during a read with slow TX.
      $display("[TB] backpressure");
      applyStimulus(8'h0A);
      baseAck = ackCount;
      rxData  = 8'h85;
      rxRdy   = 1'b1;
      stepCycle(1);
      regRdata  = 16'hA55A;
      regRvalid = 1'b1;
      stepCycle(1);
      regRvalid = 1'b0;
      stepCycle(50);
      checkOutput("bp_tx_lo", 32'({txRdy, txData}), 32'h15A);
      txAck = 1'b1;
      stepCycle(1);
      txAck = 1'b0;
      stepCycle(50);
      checkOutput("bp_tx_hi", 32'({txRdy, txData}), 32'h1A5);
      txAck = 1'b1;
      stepCycle(1);
      txAck = 1'b0;
      checkOutput("bp_no_ack_held", 32'(ackCount - baseAck), 32'd0);
      checkOutput("bp_no_ack_idle", 32'(rxAck), 32'd0);
      stepCycle(1);
      checkOutput("bp_ack_after_idle", 32'(rxAck), 32'd1);
      stepCycle(1);
      rxRdy = 1'b0;
      applyStimulus(8'h66);
      applyStimulus(8'h77);
      checkOutput("bp_we",   32'(regWe),    32'd1);
      checkOutput("bp_addr", 32'(regAddr),  32'h05);
      checkOutput("bp_data", 32'(regWdata), 32'h7766);
      stepCycle(2);

      // Byte arriving exactly in the expiry cycle of WR_LO wins.
      $display("[TB] byte in expiry cycle");
      baseErr = errPulseCount;
      applyStimulus(8'h81);
      stepCycle(14);
      applyStimulus(8'h44);
      applyStimulus(8'h33);
      checkOutput("exp_we",     32'(regWe),    32'd1);
      checkOutput("exp_addr",   32'(regAddr),  32'h01);
      checkOutput("exp_data",   32'(regWdata), 32'h3344);
      stepCycle(2);
      checkOutput("exp_no_err", 32'(errPulseCount - baseErr), 32'd0);
      checkOutput("exp_err_cnt_kept", 32'(errCnt), 32'd2);

      // Saturation: 300 more timeouts on top of the 2 already seen.
      $display("[TB] error counter saturation");
      baseErr = errPulseCount;
      baseWe  = weCount;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(8'h80);
         stepCycle(16);
      end
      checkOutput("sat_err_cnt", 32'(errCnt), 32'd255);
      checkOutput("sat_pulses",  32'(errPulseCount - baseErr), 32'd300);
      checkOutput("sat_no_we",   32'(weCount - baseWe), 32'd0);

      // Asynchronous reset in the middle of a write frame.
      $display("[TB] reset mid-frame");
      applyStimulus(8'h90);
      applyStimulus(8'hAA);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mrst_rx_ack",    32'(rxAck),    32'd0);
      checkOutput("mrst_tx_rdy",    32'(txRdy),    32'd0);
      checkOutput("mrst_tx_data",   32'(txData),   32'd0);
      checkOutput("mrst_reg_addr",  32'(regAddr),  32'd0);
      checkOutput("mrst_reg_wdata", 32'(regWdata), 32'd0);
      checkOutput("mrst_reg_we",    32'(regWe),    32'd0);
      checkOutput("mrst_reg_re",    32'(regRe),    32'd0);
      checkOutput("mrst_frame_err", 32'(frameErr), 32'd0);
      checkOutput("mrst_err_cnt",   32'(errCnt),   32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stepCycle(1);
      checkOutput("mrst_quiet", 32'({rxAck, regWe, regRe, frameErr}), 32'd0);
      applyStimulus(8'h90);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      checkOutput("mrst_we",   32'(regWe),    32'd1);
      checkOutput("mrst_addr", 32'(regAddr),  32'h10);
      checkOutput("mrst_data", 32'(regWdata), 32'h0201);
      stepCycle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
